// File: rtl/cy_elastic_buf.sv
// cy_elastic_buf: DEPTH-entry in-order valid/ready buffer with registered o_ready/o_valid/o_data.
// Define CY_ELASTIC_BUF_LEVEL_EN to expose the occupancy register on o_level.
module cy_elastic_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
`ifdef CY_ELASTIC_BUF_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] o_level
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 2);
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic          valid_q, valid_d, ready_q, ready_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] mem_q [DEPTH-1];
  logic          push, pop, ring_empty, load_in, load_ring, wr_en;
  // The output register is the head; the ring holds beats 2..DEPTH and is empty iff count <= o_valid.
  always_comb begin
    push       = i_valid & ready_q;
    pop        = valid_q & i_ready;
    ring_empty = count_q == CW'(valid_q);
    count_d    = count_q + CW'(push) - CW'(pop);
    load_in    = !valid_q || (pop && ring_empty);
    load_ring  = !load_in && pop;
    wr_en      = !load_in && push;
    data_d     = load_in ? (push ? i_data : data_q) : load_ring ? mem_q[rd_q] : data_q;
    valid_d    = count_d != '0;
    ready_d    = count_d < FULL;
    rd_d       = load_ring ? ((rd_q == LAST) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d       = wr_en ? ((wr_q == LAST) ? '0 : wr_q + 1'b1) : wr_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_q] <= i_data;
  end
  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
`ifdef CY_ELASTIC_BUF_LEVEL_EN
  assign o_level = count_q;
`endif
endmodule

// File: tb/tb_cy_elastic_buf.sv
// tb_cy_elastic_buf: scoreboard bench driving DEPTH=4, 2 and 8 instances from shared stimulus.
module tb_cy_elastic_buf;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] din = '0;
  logic       ordy [3];
  logic       ov   [3];
  logic [7:0] od   [3];
  int         n_chk = 0;
  int         n_err = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : (g == 1) ? 2 : 8;
    logic [7:0] q[$];
    logic       hold = 1'b0;
    logic [7:0] hd = '0;
`ifdef CY_ELASTIC_BUF_LEVEL_EN
    logic [$clog2(D+1)-1:0] lvl;
`endif
    cy_elastic_buf #(.DW(8), .DEPTH(D)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_valid(vld), .o_ready(ordy[g]), .i_data(din),
      .o_valid(ov[g]), .i_ready(rdy), .o_data(od[g])
`ifdef CY_ELASTIC_BUF_LEVEL_EN
      , .o_level(lvl)
`endif
    );
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        hold <= 1'b0;
      end else begin
        if (hold) check($sformatf("stable_d%0d", D), 32'(od[g]), 32'(hd));
        check($sformatf("valid_d%0d", D), 32'(ov[g]), 32'(q.size() != 0));
        check($sformatf("ready_d%0d", D), 32'(ordy[g]), 32'(q.size() < D));
`ifdef CY_ELASTIC_BUF_LEVEL_EN
        check($sformatf("level_d%0d", D), 32'(lvl), 32'(q.size()));
`endif
        if (ov[g] && rdy) begin
          if (q.size() == 0) check($sformatf("pop_empty_d%0d", D), 32'(od[g]), 32'hffff_ffff);
          else check($sformatf("order_d%0d", D), 32'(od[g]), 32'(q.pop_front()));
        end
        if (vld && ordy[g]) q.push_back(din);
        check($sformatf("bound_d%0d", D), 32'(q.size() <= D), 32'd1);
        hold <= ov[g] && !rdy;
        hd   <= od[g];
      end
    end
  end
  initial begin
    int  v;
    logic acc;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(ov[0]), 0);
    check("rst_ready", 32'(ordy[0]), 1);
    check("rst_data", 32'(od[0]), 0);
    vld = 1'b1;
    foreach (din[i]) ;
    din = 8'h11; tick();
    din = 8'h22; tick();
    din = 8'h33; tick();
    din = 8'h44; rst = 1'b1; tick();
    rst = 1'b0; vld = 1'b0;
    check("mid_rst_valid", 32'(ov[0]), 0);
    check("mid_rst_ready", 32'(ordy[0]), 1);
    check("mid_rst_data", 32'(od[0]), 0);
`ifdef CY_ELASTIC_BUF_LEVEL_EN
    check("mid_rst_level", 32'(g_dut[0].lvl), 0);
`endif
    rdy = 1'b1;
    repeat (3) tick();
    check("mid_rst_silent", 32'(ov[0]), 0);
    vld = 1'b1; din = 8'ha5; tick();
    vld = 1'b0;
    check("lat_valid", 32'(ov[0]), 1);
    check("lat_data", 32'(od[0]), 32'ha5);
    tick();
    check("lat_empty", 32'(ov[0]), 0);
    rdy = 1'b0; vld = 1'b1; v = 1;
    for (int i = 1; i <= 6; i++) begin
      din = 8'(v);
      acc = ordy[0];
      tick();
      if (acc) v++;
      check("fill_ready", 32'(ordy[0]), 32'(i < 4));
    end
    check("fill_count", 32'(v - 1), 4);
`ifdef CY_ELASTIC_BUF_LEVEL_EN
    check("fill_level", 32'(g_dut[0].lvl), 4);
`endif
    rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("drain_valid", 32'(ov[0]), 1);
      check("drain_data", 32'(od[0]), 32'(k + 1));
      din = 8'(v);
      vld = v <= 6;
      acc = vld && ordy[0];
      tick();
      if (acc) v++;
      if (k == 0) begin
        check("full_pop_ready", 32'(ordy[0]), 1);
`ifdef CY_ELASTIC_BUF_LEVEL_EN
        check("full_pop_level", 32'(g_dut[0].lvl), 3);
`endif
      end
    end
    vld = 1'b0;
    repeat (10) tick();
    vld = 1'b1;
    for (int i = 0; i < 64; i++) begin
      din = 8'(i);
      tick();
      check("stream_valid", 32'(ov[0]), 1);
      check("stream_data", 32'(od[0]), 32'(i));
`ifdef CY_ELASTIC_BUF_LEVEL_EN
      check("stream_level", 32'(g_dut[0].lvl), 1);
`endif
    end
    vld = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 10000; i++) begin
      vld = $urandom_range(0, 99) < 60;
      rdy = $urandom_range(0, 99) < 60;
      din = 8'($urandom);
      tick();
    end
    vld = 1'b0; rdy = 1'b1;
    repeat (12) tick();
    check("drain_q4", 32'(g_dut[0].q.size()), 0);
    check("drain_q2", 32'(g_dut[1].q.size()), 0);
    check("drain_q8", 32'(g_dut[2].q.size()), 0);
    check("drain_valid4", 32'(ov[0]), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cy_elastic_buf.md
# cy_elastic_buf

Parametrised elastic buffer: a DEPTH-entry, in-order valid/ready buffer with fully registered outputs. It breaks every combinational path between the upstream and downstream handshakes, so o_ready, o_valid and o_data all come from flops. It sustains one transfer per cycle and absorbs up to DEPTH beats of downstream back-pressure. It sits between pipeline stages and module boundaries wherever a single-entry skid stage cannot cover the back-pressure latency.

## Interface
- DW, 8: data width in bits, ≥1.
- DEPTH, 4: total storage in beats, including the output register. Power of two, ≥2.

- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  reset, synchronous, active-high.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  buffer can accept a beat this cycle. Registered.
- i_data  input  DW  upstream data.
- o_valid  output  1  o_data holds a beat. Registered.
- i_ready  input  1  downstream accepts the beat this cycle.
- o_data  output  DW  head-of-buffer data. Registered.
- o_level  output  $clog2(DEPTH+1)  beats currently held. Only present with CY_ELASTIC_BUF_LEVEL_EN.

## Operation
- push = i_valid & o_ready; pop = o_valid & i_ready.
- count_next = count + push − pop, with count in [0, DEPTH]. count is the internal occupancy register.
- Storage:
  - Output register: holds the head beat.
  - (DEPTH−1)-entry ring: read/write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH−1 and the wrap is handled explicitly.
- Output register load rules, evaluated in order:
  1. If the output register is empty, or pop occurs and the ring is empty: load i_data when push, else leave empty.
  2. If pop occurs and the ring is non-empty: load the ring head; a concurrent push writes to the ring tail.
  3. Otherwise a push writes to the ring tail.
- Beats leave in exactly the order they were accepted. No beat is dropped or duplicated.
- i_data is sampled only on push. It is ignored otherwise.
- While o_valid=1 and i_ready=0, o_valid and o_data hold stable until pop.
- o_ready_next = (count_next < DEPTH), registered. o_ready never depends combinationally on i_ready.
- o_valid_next = (count_next != 0).
- Full (count=DEPTH): o_ready=0, so no push. A pop in that cycle sets o_ready=1 on the next cycle.
- Empty (count=0): o_valid=0, so no pop. A push sets o_valid=1 on the next cycle.
- Simultaneous push and pop at 0<count<DEPTH: count is unchanged; head advances and the new beat lands at the tail.

## Timing
- Reset: count=0, pointers=0, o_valid=0, o_ready=1, o_data=0, o_level=0. These values appear in the cycle after the edge that samples i_reset=1.
- i_reset wins over simultaneous push/pop. Beats held at reset are discarded.
- Latency: a beat pushed at edge N into an empty buffer is on o_data with o_valid=1 after edge N, i.e. one cycle.
- Throughput: with i_valid=i_ready=1 held continuously, one beat transfers per cycle indefinitely, with no bubbles.
- Back-pressure: with i_ready=0, the buffer accepts exactly DEPTH beats, then drops o_ready the cycle after the DEPTH-th push.
- Recovery: after the first pop from full, o_ready=1 one cycle later.

## Configuration
- CY_ELASTIC_BUF_LEVEL_EN defined:
  - Port o_level is present and driven as a register equal to count.
  - It updates on the same edge as count and resets to 0.
- Not defined: the port and its logic are absent. Handshake and data behaviour are identical in both builds.

## Test plan
- Reset mid-stream: push 3 beats (0x11, 0x22, 0x33), assert i_reset with i_valid=1 → next cycle o_valid=0, o_ready=1, o_data=0, o_level=0. Beats 0x11–0x33 are never emitted.
- Latency: push 0xA5 into an empty buffer with i_ready=1 → o_valid=1, o_data=0xA5 the next cycle. o_valid=0 one cycle later if no further push.
- Fill/drain, DEPTH=4, i_ready=0:
  - Push 0x01..0x06 continuously → only 0x01..0x04 accepted; o_ready=0 from the cycle after the 4th push; o_level=4.
  - Then i_ready=1 → out 0x01,0x02,0x03,0x04 then 0x05,0x06 on consecutive cycles.
- Streaming: i_valid=i_ready=1 for 64 cycles with incrementing data → 64 beats out in order, one per cycle, o_level constant at 1 after the first cycle.
- Wrap-around: random i_valid/i_ready, 60% density each, 10,000 cycles, DEPTH=2 and DEPTH=8 → scoreboard exact order, no loss.
  - Across the whole run, at every cycle: o_data stable while o_valid&!i_ready, and count never exceeds DEPTH.
- Simultaneous push/pop at full: count=DEPTH, i_ready=1, i_valid=1 → the pop completes but no push that cycle; o_ready=1 the next cycle; o_level goes 4→3.
